fp_vector_add: RTL and testbench
================================

Name: fp_vector_add

Overview:
- Four-lane, pipelined floating-point adder computing a_out=a_1+a_2, b_out=b_1+b_2, c_out=c_1+c_2 and d_out=d_1+d_2 in parallel.
- Uses a parameterised minifloat format: sign, EXP_BITS exponent, MANT_BITS fraction. The default format is 12 bits (1/5/6).
- Serves as the vector add/accumulate element of the TPU datapath.
- Has a fixed-latency valid pipeline and no backpressure.

Parameters:
- EXP_BITS, 5, exponent field width; bias = 2^(EXP_BITS-1)-1 (15 by default).
- MANT_BITS, 6, stored fraction width; the hidden bit is implicit.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  all eight operands are valid this cycle.
- a_1, b_1, c_1, d_1  input  EXP_BITS+MANT_BITS+1 each  first operand per lane.
- a_2, b_2, c_2, d_2  input  EXP_BITS+MANT_BITS+1 each  second operand per lane.
- a_out, b_out, c_out, d_out  output  EXP_BITS+MANT_BITS+1 each  registered lane sums.
- out_valid  output  1  the lane sums are valid this cycle.

Behaviour:
- Word layout: {sign[MSB], exp[EXP_BITS], frac[MANT_BITS]}. All four lanes are identical and independent.
- Reset (rst=0, asynchronous): all pipeline registers clear, every *_out = 0, out_valid = 0. Asserting reset mid-operation discards all in-flight results.
- Pipeline is 3 register stages, so latency = 3 cycles:
  - S1: unpack, classify, swap so the larger magnitude is first, align the smaller significand with guard/round/sticky bits.
  - S2: add or subtract the significands.
  - S3: leading-zero normalise, round, pack.
- in_valid is sampled every cycle. out_valid equals in_valid delayed by exactly 3 cycles. Back-to-back inputs give back-to-back outputs (throughput 1/cycle).
- Output data registers load only when the S3 stage is valid. Otherwise they hold their last value.
- Subnormal handling: an exponent field of 0 is treated as zero regardless of the fraction (flush-to-zero). Results below the minimum normal flush to a signed zero.
- Rounding: round-to-nearest, ties-to-even.
- Zero results:
  - Exact cancellation (x + -x) yields +0.
  - (-0) + (-0) yields -0.
  - Any other pair of zeros yields +0.
- Special operands (exponent all ones):
  - Fraction 0 is Inf; fraction non-zero is NaN.
  - Inf + finite = that Inf. Inf + Inf of the same sign = Inf.
  - Inf + (-Inf) = NaN. NaN in either operand = NaN.
  - The canonical NaN is sign 0, exp all ones, fraction MSB 1 and other fraction bits 0.
- Overflow after rounding (exp ≥ all ones) produces a signed Inf.
- Alignment: if the exponent difference exceeds MANT_BITS+3, the smaller operand contributes only to the sticky bit.

Optional Feature:
- Macro FP_ADD_SATURATE_EN.
- When defined: finite-operand overflow returns the signed maximum finite value (exp all-ones minus 1, fraction all ones) instead of Inf. Inf and NaN operands are still propagated as specified above.
- When undefined: overflow returns signed Inf.

Test Plan:
- Reset/latency: hold rst=0 for 2 cycles → all outputs 0, out_valid 0. Release, drive in_valid=1 for 2 cycles, then 0 → out_valid high exactly on cycles 3 and 4 after the first valid edge, then low.
- Doubling lanes: a=0_10000_100100 (3.125), b=0_01111_110100 (1.8125), c=1_01111_110100, d=1_10001_010100 (-5.25); second operands a,b,c and 0 for d:
  - a_out = 0_10000_100100 + itself → 0_10001_100100 (6.25)
  - b_out → 0_10000_110100 (3.625)
  - c_out → 1_10000_110100
  - d_out → 1_10001_010100 (unchanged)
- Subtraction/normalise: 0_01111_110100 + 1_10001_010100 → 1_10000_101110 (-3.4375). 0_10000_100100 + 1_10000_100100 → 0_00000_000000.
- Rounding ties-to-even: 0_01111_000001 + 0_01111_000000 (exact 2.015625, tie) → 0_10000_000000. 0_01111_000011 + 0_01111_000000 → 0_10000_000010.
- Specials: 0_11111_000000 + 1_11111_000000 → NaN 0_11111_100000. 0_11110_111111 + same → 0_11111_000000, or with FP_ADD_SATURATE_EN → 0_11110_111111. 0_00000_010000 + 0_00000_000000 → 0_00000_000000 (flush).
- Reset mid-stream: assert rst while 3 results are in flight → out_valid drops immediately, no stale results appear after release.

Source files
------------

// File: rtl/fp_vector_add.sv
// fp_vector_add: four-lane 3-stage minifloat adder (flush-to-zero, RNE rounding).
// Define FP_ADD_SATURATE_EN to saturate finite overflow to the max finite value.
module fp_vector_add #(
  parameter int EXP_BITS  = 5,
  parameter int MANT_BITS = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [EXP_BITS+MANT_BITS:0]  a_1,
  input  logic [EXP_BITS+MANT_BITS:0]  b_1,
  input  logic [EXP_BITS+MANT_BITS:0]  c_1,
  input  logic [EXP_BITS+MANT_BITS:0]  d_1,
  input  logic [EXP_BITS+MANT_BITS:0]  a_2,
  input  logic [EXP_BITS+MANT_BITS:0]  b_2,
  input  logic [EXP_BITS+MANT_BITS:0]  c_2,
  input  logic [EXP_BITS+MANT_BITS:0]  d_2,
  output logic [EXP_BITS+MANT_BITS:0]  a_out,
  output logic [EXP_BITS+MANT_BITS:0]  b_out,
  output logic [EXP_BITS+MANT_BITS:0]  c_out,
  output logic [EXP_BITS+MANT_BITS:0]  d_out,
  output logic                         out_valid
);
  localparam int W  = EXP_BITS + MANT_BITS + 1;
  localparam int SW = MANT_BITS + 4;
  localparam int EW = EXP_BITS + 3;
  localparam logic [EXP_BITS-1:0] EMAX = '1;
  localparam logic [W-1:0] QNAN = {1'b0, EMAX, 1'b1, {(MANT_BITS-1){1'b0}}};

  logic [W-1:0] w_x [4];
  logic [W-1:0] w_y [4];
  logic [W-1:0] w_o [4];
  logic [2:0]   r_v;

  assign w_x = '{a_1, b_1, c_1, d_1};
  assign w_y = '{a_2, b_2, c_2, d_2};
  assign a_out = w_o[0];
  assign b_out = w_o[1];
  assign c_out = w_o[2];
  assign d_out = w_o[3];
  assign out_valid = r_v[2];

  always_ff @(posedge clk or negedge rst)
    if (!rst) r_v <= '0;
    else r_v <= {r_v[1:0], in_valid};

  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic                 w_sx, w_sy, w_zx, w_zy, w_ix, w_iy, w_nan, w_swap;
    logic [EXP_BITS-1:0]  w_ex, w_ey, w_eb, w_es, w_d;
    logic [MANT_BITS-1:0] w_fx, w_fy;
    logic [SW-1:0]        w_mb, w_ms, w_ma;
    logic [2*SW-1:0]      w_wide;
    logic                 r1_s, r1_sub, r1_zs, r1_spec, r2_s, r2_zs, r2_spec;
    logic [EXP_BITS-1:0]  r1_e, r2_e;
    logic [SW-1:0]        r1_mb, r1_ms;
    logic [SW:0]          r2_sum, w_n;
    logic [W-1:0]         r1_sv, r2_sv, w_ovf, w_res, r_out;
    logic [7:0]           w_lz;
    logic [MANT_BITS:0]   w_rf;
    logic                 w_inc;
    logic [EW-1:0]        w_e;

    assign {w_sx, w_ex, w_fx} = w_x[g];
    assign {w_sy, w_ey, w_fy} = w_y[g];
    assign w_zx = w_ex == '0;
    assign w_zy = w_ey == '0;
    assign w_ix = w_ex == EMAX && w_fx == '0;
    assign w_iy = w_ey == EMAX && w_fy == '0;
    assign w_nan = (w_ex == EMAX && w_fx != '0) | (w_ey == EMAX && w_fy != '0) | (w_ix & w_iy & (w_sx ^ w_sy));
    // flushed operands compare as magnitude zero so the real operand lands first
    assign w_swap = (w_zx ? '0 : {w_ex, w_fx}) < (w_zy ? '0 : {w_ey, w_fy});
    assign w_eb = w_swap ? w_ey : w_ex;
    assign w_es = w_swap ? w_ex : w_ey;
    assign w_mb = (w_swap ? w_zy : w_zx) ? '0 : {1'b1, w_swap ? w_fy : w_fx, 3'b000};
    assign w_ms = (w_swap ? w_zx : w_zy) ? '0 : {1'b1, w_swap ? w_fx : w_fy, 3'b000};
    assign w_d = w_eb - w_es;
    assign w_wide = w_d > EXP_BITS'(SW) ? {{SW{1'b0}}, w_ms} : {w_ms, {SW{1'b0}}} >> w_d;
    assign w_ma = {w_wide[2*SW-1:SW+1], w_wide[SW] | (|w_wide[SW-1:0])};

    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        {r1_s, r1_sub, r1_zs, r1_spec, r1_e, r1_mb, r1_ms, r1_sv} <= '0;
        {r2_s, r2_zs, r2_spec, r2_e, r2_sum, r2_sv} <= '0;
        r_out <= '0;
      end else begin
        r1_s    <= w_swap ? w_sy : w_sx;
        r1_sub  <= w_sx ^ w_sy;
        r1_zs   <= w_sx & w_sy;
        r1_spec <= w_nan | w_ix | w_iy;
        r1_sv   <= w_nan ? QNAN : {w_ix ? w_sx : w_sy, EMAX, {MANT_BITS{1'b0}}};
        r1_e    <= w_eb;
        r1_mb   <= w_mb;
        r1_ms   <= w_ma;
        r2_s    <= r1_s;
        r2_zs   <= r1_zs;
        r2_spec <= r1_spec;
        r2_sv   <= r1_sv;
        r2_e    <= r1_e;
        r2_sum  <= r1_sub ? {1'b0, r1_mb} - {1'b0, r1_ms} : {1'b0, r1_mb} + {1'b0, r1_ms};
        if (r_v[1]) r_out <= w_res;
      end

    always_comb begin
      w_lz = '0;
      for (int i = 0; i <= SW; i++) if (r2_sum[i]) w_lz = 8'(SW - i);
    end

    assign w_n = r2_sum << w_lz;
    assign w_inc = w_n[3] & (w_n[4] | (|w_n[2:0]));
    assign w_rf = {1'b0, w_n[SW-1:4]} + (MANT_BITS+1)'(w_inc);
    assign w_e = EW'(r2_e) + EW'(1) - EW'(w_lz) + EW'(w_rf[MANT_BITS]);
`ifdef FP_ADD_SATURATE_EN
    assign w_ovf = {r2_s, EMAX - 1'b1, {MANT_BITS{1'b1}}};
`else
    assign w_ovf = {r2_s, EMAX, {MANT_BITS{1'b0}}};
`endif
    // a normalised MSB of 0 means the significand sum was exactly zero
    assign w_res = r2_spec ? r2_sv :
                   !w_n[SW] ? {r2_zs, {(W-1){1'b0}}} :
                   (w_e[EW-1] || w_e == '0) ? {r2_s, {(W-1){1'b0}}} :
                   w_e >= EW'(EMAX) ? w_ovf :
                   {r2_s, w_e[EXP_BITS-1:0], w_rf[MANT_BITS-1:0]};
    assign w_o[g] = r_out;
  end
endmodule

// File: tb/tb_fp_vector_add.sv
// tb_fp_vector_add: directed checks of latency, arithmetic, specials and reset for fp_vector_add.
module tb_fp_vector_add;
  logic clk = 1'b0;
  logic rst, in_valid;
  logic [11:0] a_1, b_1, c_1, d_1, a_2, b_2, c_2, d_2;
  logic [11:0] a_out, b_out, c_out, d_out;
  logic out_valid;
  int checks = 0;
  int errors = 0;

  localparam logic [11:0] INF  = 12'b0_11111_000000;
  localparam logic [11:0] NINF = 12'b1_11111_000000;
  localparam logic [11:0] QNAN = 12'b0_11111_100000;
  localparam logic [11:0] MAXF = 12'b0_11110_111111;
  localparam logic [11:0] ONE  = 12'b0_01111_000000;
`ifdef FP_ADD_SATURATE_EN
  localparam logic [11:0] OVF = MAXF;
`else
  localparam logic [11:0] OVF = INF;
`endif

  always #5 clk = ~clk;

  fp_vector_add dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .a_1(a_1), .b_1(b_1), .c_1(c_1), .d_1(d_1),
    .a_2(a_2), .b_2(b_2), .c_2(c_2), .d_2(d_2),
    .a_out(a_out), .b_out(b_out), .c_out(c_out), .d_out(d_out),
    .out_valid(out_valid)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [11:0] x1, x2, y1, y2, z1, z2, w1, w2);
    in_valid = v;
    a_1 = x1; a_2 = x2; b_1 = y1; b_2 = y2;
    c_1 = z1; c_2 = z2; d_1 = w1; d_2 = w2;
  endtask

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic v, input logic [11:0] ea, eb, ec, ed);
    chk({tag, ".valid"}, {11'b0, out_valid}, {11'b0, v});
    chk({tag, ".a"}, a_out, ea);
    chk({tag, ".b"}, b_out, eb);
    chk({tag, ".c"}, c_out, ec);
    chk({tag, ".d"}, d_out, ed);
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b1, ONE, ONE, ONE, ONE, ONE, ONE, ONE, ONE);
    step;
    step;
    chk4("reset", 1'b0, 12'h000, 12'h000, 12'h000, 12'h000);
    rst = 1'b1;
    drive(1'b1, 12'b0_10000_100100, 12'b0_10000_100100, 12'b0_01111_110100, 12'b0_01111_110100,
          12'b1_01111_110100, 12'b1_01111_110100, 12'b1_10001_010100, 12'b0_00000_000000);
    step;
    chk("lat1.valid", {11'b0, out_valid}, 12'd0);
    drive(1'b1, 12'b0_01111_110100, 12'b1_10001_010100, 12'b0_10000_100100, 12'b1_10000_100100,
          12'b0_01111_000001, 12'b0_01111_000000, 12'b0_01111_000011, 12'b0_01111_000000);
    step;
    chk("lat2.valid", {11'b0, out_valid}, 12'd0);
    drive(1'b1, INF, NINF, MAXF, MAXF, 12'b0_00000_010000, 12'b0_00000_000000,
          12'b1_00000_000000, 12'b1_00000_000000);
    step;
    chk4("double", 1'b1, 12'b0_10001_100100, 12'b0_10000_110100, 12'b1_10000_110100, 12'b1_10001_010100);
    drive(1'b1, NINF, ONE, 12'b1_11111_000001, ONE, 12'b0_10000_111111, 12'b0_01111_000001,
          12'b0_00001_000001, 12'b1_00001_000000);
    step;
    chk4("subround", 1'b1, 12'b1_10000_101110, 12'b0_00000_000000, 12'b0_10000_000000, 12'b0_10000_000010);
    in_valid = 1'b0;
    step;
    chk4("special", 1'b1, QNAN, OVF, 12'b0_00000_000000, 12'b1_00000_000000);
    step;
    chk4("misc", 1'b1, NINF, QNAN, 12'b0_10001_010000, 12'b0_00000_000000);
    step;
    chk4("hold", 1'b0, NINF, QNAN, 12'b0_10001_010000, 12'b0_00000_000000);
    drive(1'b1, 12'b0_10100_000000, 12'b0_01000_000001, 12'b1_10000_000000, ONE,
          ONE, 12'b0_01110_000001, 12'b1_01111_000011, 12'b1_01111_000000);
    step;
    step;
    step;
    chk4("stream", 1'b1, 12'b0_10100_000000, 12'b1_01111_000000, 12'b0_01111_100000, 12'b1_10000_000010);
    rst = 1'b0;
    #1;
    chk4("async_rst", 1'b0, 12'h000, 12'h000, 12'h000, 12'h000);
    in_valid = 1'b0;
    step;
    step;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step;
      chk4("post_rst", 1'b0, 12'h000, 12'h000, 12'h000, 12'h000);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
